// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: RV32I base opcodes and loader state enum
// Contents:
//   OP_*               7-bit major opcodes, shared with the instruction decoder
//   loader_state_t     instruction-loader FSM states {LEN, DATA, DONE}
//   opcode_supported() 1 when an opcode is one of the supported major opcodes
package cpu_pkg;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    LEN  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_supported = 1'b1;
      default:                           opcode_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// rtl/inst_loader_if.sv - instruction-memory write bus between loader and memory
// Signals:
//   imem_wr_en    write strobe, one cycle per word
//   imem_addr     word address (ADDR_W bits)
//   imem_wr_data  32-bit instruction word
// Modports: master = loader (drives), slave = instruction memory (receives)
interface inst_loader_if #(
  parameter int ADDR_W = 12
);

  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wr_data;

  modport master (output imem_wr_en, output imem_addr, output imem_wr_data);
  modport slave  (input  imem_wr_en, input  imem_addr, input  imem_wr_data);

endinterface

// File: rtl/inst_word_packer.sv
// rtl/inst_word_packer.sv - packs a little-endian byte stream into 32-bit words
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous restart: lane counter back to byte 0
//   byte_valid   byte_data is consumed on this edge
//   byte_data    incoming byte
//   word         assembled word {b3,b2,b1,b0}, valid while word_done=1
//   word_done    combinational strobe: this edge consumes byte 3 of a word
module inst_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  lane;
  // Only bytes 0..2 need storage; byte 3 is taken straight from the input
  // so the full word is available on the edge that completes it.
  logic [23:0] low_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (clear) begin
      lane      <= 2'd0;
      low_bytes <= 24'd0;
    end else if (byte_valid) begin
      lane      <= lane + 2'd1;
      low_bytes <= {byte_data, low_bytes[23:8]};
    end
  end

  assign word      = {byte_data, low_bytes};
  assign word_done = byte_valid && (lane == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - loads a UART byte stream (count + words) into instruction memory
// Optional feature macro: INST_LOADER_OPCODE_CHECK_EN (flags unsupported opcodes on bad_inst)
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rx_valid    one-cycle pulse, rx_data holds a received byte
//   rx_data     received byte
//   reload      one-cycle pulse, restart loading from the count field
//   imem        instruction-memory write bus (inst_loader_if.master)
//   load_done   level, whole program loaded
//   overflow    sticky, program longer than 2**ADDR_W words
//   bad_inst    sticky, unsupported opcode written (0 without the macro)
module inst_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  input  logic         reload,
  inst_loader_if.master imem,
  output logic         load_done,
  output logic         overflow,
  output logic         bad_inst
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  loader_state_t state;
  logic [31:0]   count_n;
  logic [31:0]   word_idx;
  logic          accept;
  logic          word_done;
  logic [31:0]   word;
  logic          in_range;
  logic          last_word;

  // reload wins over a simultaneous byte; DONE ignores the stream entirely.
  assign accept    = rx_valid && !reload && (state != DONE);
  assign in_range  = word_idx < DEPTH;
  assign last_word = (word_idx + 32'd1) == count_n;

  inst_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload),
    .byte_valid (accept),
    .byte_data  (rx_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= LEN;
      count_n           <= 32'd0;
      word_idx          <= 32'd0;
      imem.imem_wr_en   <= 1'b0;
      imem.imem_addr    <= '0;
      imem.imem_wr_data <= 32'd0;
      load_done         <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      imem.imem_wr_en <= 1'b0;
      if (reload) begin
        state     <= LEN;
        count_n   <= 32'd0;
        word_idx  <= 32'd0;
        load_done <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          LEN: begin
            if (word_done) begin
              count_n <= word;
              if (word == 32'd0) begin
                // Empty program: done as soon as the count is in.
                state     <= DONE;
                load_done <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (word_done) begin
              if (in_range) begin
                imem.imem_wr_en   <= 1'b1;
                imem.imem_addr    <= word_idx[ADDR_W-1:0];
                imem.imem_wr_data <= word;
              end
              if (word_idx == DEPTH) begin
                overflow <= 1'b1;
              end
              word_idx <= word_idx + 32'd1;
              if (last_word) begin
                state <= DONE;
              end
            end
          end
          DONE: begin
            // First DONE cycle coincides with the final strobe, so the flag
            // becomes visible the cycle after it.
            load_done <= 1'b1;
          end
          default: begin
            state <= LEN;
          end
        endcase
      end
    end
  end

`ifdef INST_LOADER_OPCODE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_inst <= 1'b0;
    end else if (reload) begin
      bad_inst <= 1'b0;
    end else if (state == DATA && word_done && in_range &&
                 !opcode_supported(word[6:0])) begin
      bad_inst <= 1'b1;
    end
  end
`else
  assign bad_inst = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard testbench for inst_loader (ADDR_W=2, DEPTH=4)
module tb_inst_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
`ifdef INST_LOADER_OPCODE_CHECK_EN
  localparam bit OPC_CHK = 1'b1;
`else
  localparam bit OPC_CHK = 1'b0;
`endif

  typedef logic [7:0] byteq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       reload = 1'b0;
  logic       load_done, overflow, bad_inst;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .reload    (reload),
    .imem      (bus),
    .load_done (load_done),
    .overflow  (overflow),
    .bad_inst  (bad_inst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];   // {addr(2), data(32)}
  bit exp_done, exp_ovf, exp_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e[33:32]));
        check("wr_data", bus.imem_wr_data, e[31:0]);
      end
    end
  end

  function automatic bit legal_op(input logic [6:0] op);
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: interpret the byte stream as count + words, as a whole.
  task automatic model(input byteq_t bs);
    longint n, avail, k;
    logic [31:0] w;
    exp_done = 0; exp_ovf = 0; exp_bad = 0;
    if (bs.size() < 4) return;
    n = {bs[3], bs[2], bs[1], bs[0]};
    avail = (bs.size() - 4) / 4;
    k = (n < avail) ? n : avail;
    for (int i = 0; i < k; i++) begin
      w = {bs[4+4*i+3], bs[4+4*i+2], bs[4+4*i+1], bs[4+4*i]};
      if (i < DEPTH) begin
        exp_q.push_back({2'(i), w});
        if (OPC_CHK && !legal_op(w[6:0])) exp_bad = 1;
      end
    end
    exp_done = (avail >= n);
    exp_ovf  = (k > DEPTH);
  endtask

  task automatic add_word(inout byteq_t bs, input logic [31:0] w);
    for (int i = 0; i < 4; i++) bs.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 8)];
    return r;
  endfunction

  // All drivers enter and leave 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_load_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_overflow"},  32'(overflow),  32'(exp_ovf));
    check({tag, "_bad_inst"},  32'(bad_inst),  32'(exp_bad));
  endtask

  task automatic run_stream(input string tag, input byteq_t bs, input bit do_reload,
                            input bit timing, input bit gaps);
    if (do_reload) pulse_reload();
    model(bs);
    foreach (bs[i]) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(bs[i]);
    end
    if (timing) begin
      if ({bs[3], bs[2], bs[1], bs[0]} == 32'd0) begin
        check({tag, "_done_at_count"}, 32'(load_done), 32'd1);
        check({tag, "_no_strobe"}, 32'(bus.imem_wr_en), 32'd0);
      end else begin
        check({tag, "_strobe_now"}, 32'(bus.imem_wr_en), 32'd1);
        check({tag, "_done_not_yet"}, 32'(load_done), 32'd0);
        idle(1);
        check({tag, "_done_next"}, 32'(load_done), 32'd1);
      end
    end
    idle(3);
    check_flags(tag);
  endtask

  initial begin
    byteq_t bs;

    // Reset state, driven asynchronously before any clock edge.
    #2;
    check("rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_data", bus.imem_wr_data, 32'd0);
    check("rst_flags", {29'd0, load_done, overflow, bad_inst}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Two-word program straight out of reset.
    bs = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h33, 8'h06, 8'hb5, 8'h00};
    run_stream("two_words", bs, 1'b0, 1'b1, 1'b0);

    // Empty program.
    bs = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_stream("empty", bs, 1'b1, 1'b1, 1'b0);

    // Five words into a four-word memory.
    bs = '{8'h05, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) add_word(bs, 32'h0000_0013 | (32'(i) << 20));
    run_stream("overflow", bs, 1'b1, 1'b0, 1'b1);
    check("ovf_directed", 32'(overflow), 32'd1);
    check("ovf_done_directed", 32'(load_done), 32'd1);

    // Unsupported opcode word.
    bs = '{8'h01, 8'h00, 8'h00, 8'h00};
    add_word(bs, 32'h0000_007F);
    run_stream("bad_op", bs, 1'b1, 1'b1, 1'b0);
    check("bad_op_directed", 32'(bad_inst), 32'(OPC_CHK));

    // Asynchronous reset in the middle of word 1.
    pulse_reload();
    bs = '{8'h02, 8'h00, 8'h00, 8'h00};
    add_word(bs, 32'hDEAD_B0B3);
    bs.push_back(8'h11);
    bs.push_back(8'h22);
    model(bs);
    foreach (bs[i]) send_byte(bs[i]);
    idle(1);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", 32'(bus.imem_wr_en), 32'd0);
    check("midrst_addr", 32'(bus.imem_addr), 32'd0);
    check("midrst_data", bus.imem_wr_data, 32'd0);
    check("midrst_flags", {29'd0, load_done, overflow, bad_inst}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bs = '{8'h02, 8'h00, 8'h00, 8'h00};
    add_word(bs, 32'h0010_0093);
    add_word(bs, 32'h0020_8113);
    run_stream("after_rst", bs, 1'b0, 1'b1, 1'b0);

    // reload colliding with a data byte: byte dropped, flags cleared.
    pulse_reload();
    bs = '{8'h06, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) add_word(bs, rand_word());
    add_word(bs, 32'h0000_007F);
    model(bs);
    foreach (bs[i]) send_byte(bs[i]);
    check("pre_reload_ovf", 32'(overflow), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    reload   = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    reload   = 1'b0;
    check("reload_flags", {29'd0, load_done, overflow, bad_inst}, 32'd0);
    bs = '{8'h01, 8'h00, 8'h00, 8'h00};
    add_word(bs, 32'h0000_0537);
    run_stream("after_reload", bs, 1'b0, 1'b1, 1'b0);

    // Randomised programs, with trailing bytes that DONE must ignore.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 6);
      bs = '{};
      add_word(bs, 32'(n));
      for (int i = 0; i < n; i++) add_word(bs, rand_word());
      repeat ($urandom_range(0, 3)) bs.push_back(8'($urandom));
      run_stream("rand", bs, 1'b1, 1'b0, 1'b1);
    end

    idle(4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
